majority_voter_tmr_monitor: RTL and testbench

//  Registered, flow-controlled N-way majority voter with per-channel health tracking.

---
 rtl/majority_voter_tmr_monitor_if.sv | 24 ++
 rtl/majority_voter_tmr_monitor.sv | 113 +++++++++++
 tb/tb_majority_voter_tmr_monitor.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/majority_voter_tmr_monitor_if.sv
// Beat-level handshake bundle between redundant lanes, the voter and its consumer.
interface majority_voter_tmr_monitor_if #(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned NUM_INPUTS  = 3
);
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_INPUTS*INPUT_WIDTH-1:0] in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [INPUT_WIDTH-1:0]            out_data;
  logic                              out_majority;
  logic [NUM_INPUTS-1:0]             out_disagree;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_majority, out_disagree
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_majority, out_disagree
  );
endinterface

// File: rtl/majority_voter_tmr_monitor.sv
// Registered N-way majority voter with per-channel miscompare streak tracking and isolation.
module majority_voter_tmr_monitor #(
  parameter int unsigned INPUT_WIDTH     = 8,
  parameter int unsigned NUM_INPUTS      = 3,
  parameter int unsigned MAJORITY_LEVEL  = NUM_INPUTS / 2 + 1,
  parameter int unsigned FAULT_THRESHOLD = 4,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  majority_voter_tmr_monitor_if.slave bus,
  input  logic [NUM_INPUTS-1:0]       chan_enable,
  input  logic                        clear_faults,
  output logic [NUM_INPUTS-1:0]       fault,
  output logic [CNT_WIDTH-1:0]        nomaj_count
);
  localparam int unsigned VOTE_W   = $clog2(NUM_INPUTS + 1);
  localparam int unsigned STREAK_W = $clog2(FAULT_THRESHOLD + 1);

  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAILED} health_e;

  health_e                state  [NUM_INPUTS];
  logic [STREAK_W-1:0]    streak [NUM_INPUTS];
  logic [INPUT_WIDTH-1:0] ch     [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  active;
  logic [NUM_INPUTS-1:0]  disagree;
  logic [INPUT_WIDTH-1:0] voted;
  logic                   majority;
  logic [VOTE_W-1:0]      votes;
  logic                   accept;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign active       = chan_enable & ~fault;

  // Lowest-index active channel whose value reaches the majority level wins.
  always_comb begin
    majority = 1'b0;
    voted    = '0;
    disagree = '0;
    votes    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ch[i] = bus.in_data[i*INPUT_WIDTH +: INPUT_WIDTH];
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      votes = '0;
      for (int j = 0; j < NUM_INPUTS; j++) begin
        if (active[j] && (ch[j] == ch[i])) votes = votes + VOTE_W'(1);
      end
      if (!majority && active[i] && (votes >= VOTE_W'(MAJORITY_LEVEL))) begin
        majority = 1'b1;
        voted    = ch[i];
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      disagree[i] = majority && active[i] && (ch[i] != voted);
    end
  end

  // Output register and no-majority counter; fields hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      bus.out_majority <= 1'b0;
      bus.out_disagree <= '0;
      nomaj_count      <= '0;
    end else if (accept) begin
      bus.out_valid    <= 1'b1;
      bus.out_data     <= voted;
      bus.out_majority <= majority;
      bus.out_disagree <= disagree;
      if (!majority && (nomaj_count != {CNT_WIDTH{1'b1}})) begin
        nomaj_count <= nomaj_count + CNT_WIDTH'(1);
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Per-channel health FSM; clear_faults wins over the same beat's streak update.
  always_ff @(posedge clk) begin
    if (rst || clear_faults) begin
      fault <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        state[i]  <= ST_OK;
        streak[i] <= '0;
      end
    end else if (accept && majority) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        case (state[i])
          ST_OK, ST_SUSPECT: begin
            if (active[i]) begin
              if (disagree[i]) begin
                streak[i] <= streak[i] + STREAK_W'(1);
                if (streak[i] == STREAK_W'(FAULT_THRESHOLD - 1)) begin
                  state[i] <= ST_FAILED;
                  fault[i] <= 1'b1;
                end else begin
                  state[i] <= ST_SUSPECT;
                end
              end else begin
                streak[i] <= '0;
                state[i]  <= ST_OK;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_majority_voter_tmr_monitor.sv
// Bench for majority_voter_tmr_monitor: directed vector table, hand sequences, randomized model check.
module tb_majority_voter_tmr_monitor;
  localparam int unsigned W   = 8;
  localparam int unsigned N   = 3;
  localparam int unsigned THR = 4;
  localparam int unsigned CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  en;
  logic          clr;
  logic [N-1:0]  fault;
  logic [CW-1:0] nomaj;

  always #5 clk = ~clk;

  majority_voter_tmr_monitor_if #(.INPUT_WIDTH(W), .NUM_INPUTS(N)) bus ();

  majority_voter_tmr_monitor #(
    .INPUT_WIDTH(W), .NUM_INPUTS(N), .MAJORITY_LEVEL(N/2+1),
    .FAULT_THRESHOLD(THR), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .chan_enable(en),
    .clear_faults(clr), .fault(fault), .nomaj_count(nomaj)
  );

  typedef struct {
    logic [N*W-1:0] data;
    logic [N-1:0]   en;
    logic           clr;
    logic [W-1:0]   e_data;
    logic           e_maj;
    logic [N-1:0]   e_dis;
    logic [N-1:0]   e_fault;
    logic [CW-1:0]  e_nomaj;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  // Reference state, kept as plain integers and bits.
  int           m_streak[N];
  bit           m_fault[N];
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_maj;
  logic [N-1:0] m_dis;
  int           m_nomaj;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  function automatic logic [N-1:0] m_fault_vec();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = m_fault[i];
    return f;
  endfunction

  function automatic void ref_vote(input logic [N*W-1:0] d, input logic [N-1:0] e,
                                   output bit maj, output logic [W-1:0] v, output logic [N-1:0] dis);
    logic [W-1:0] w[N];
    bit           act[N];
    int           cnt;
    maj = 0; v = '0; dis = '0;
    for (int i = 0; i < N; i++) begin
      w[i]   = d[i*W +: W];
      act[i] = e[i] && !m_fault[i];
    end
    for (int i = 0; i < N; i++) begin
      if (!maj && act[i]) begin
        cnt = 0;
        for (int j = 0; j < N; j++) if (act[j] && w[j] == w[i]) cnt++;
        if (cnt >= int'(N/2 + 1)) begin maj = 1; v = w[i]; end
      end
    end
    if (maj) for (int i = 0; i < N; i++) dis[i] = act[i] && (w[i] != v);
  endfunction

  task automatic model_edge(input bit r, input bit vld, input logic [N*W-1:0] d,
                            input logic [N-1:0] e, input bit c, input bit ordy);
    bit           acc, maj;
    logic [W-1:0] v;
    logic [N-1:0] dis;
    if (r) begin
      m_valid = 0; m_data = '0; m_maj = 0; m_dis = '0; m_nomaj = 0;
      for (int i = 0; i < N; i++) begin m_streak[i] = 0; m_fault[i] = 0; end
      return;
    end
    acc = vld && (!m_valid || ordy);
    ref_vote(d, e, maj, v, dis);
    if (acc) begin
      m_valid = 1; m_data = v; m_maj = maj; m_dis = dis;
      if (!maj && m_nomaj < (1 << CW) - 1) m_nomaj++;
      if (maj && !c) begin
        for (int i = 0; i < N; i++) begin
          if (e[i] && !m_fault[i]) begin
            if (dis[i]) begin
              m_streak[i]++;
              if (m_streak[i] >= int'(THR)) m_fault[i] = 1;
            end else m_streak[i] = 0;
          end
        end
      end
    end else if (ordy) m_valid = 0;
    if (c) for (int i = 0; i < N; i++) begin m_streak[i] = 0; m_fault[i] = 0; end
  endtask

  // Drive one cycle of inputs, check in_ready, advance the clock and the model.
  task automatic cycle(input bit r, input bit vld, input logic [N*W-1:0] d,
                       input logic [N-1:0] e, input bit c, input bit ordy);
    rst = r; bus.in_valid = vld; bus.in_data = d; en = e; clr = c; bus.out_ready = ordy;
    #1;
    if (!r) chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
    @(posedge clk);
    model_edge(r, vld, d, e, c, ordy);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " out_valid"},    32'(bus.out_valid),    32'(m_valid));
    chk({tag, " out_data"},     32'(bus.out_data),     32'(m_data));
    chk({tag, " out_majority"}, 32'(bus.out_majority), 32'(m_maj));
    chk({tag, " out_disagree"}, 32'(bus.out_disagree), 32'(m_dis));
    chk({tag, " fault"},        32'(fault),            32'(m_fault_vec()));
    chk({tag, " nomaj_count"},  32'(nomaj),            32'(m_nomaj));
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic [W-1:0]   base;
    bit             r, c, vld, ordy;
    logic [N-1:0]   e;

    // ch data packed as {ch2, ch1, ch0}
    vecs.push_back('{24'hA5A5A5, 3'b111, 1'b0, 8'hA5, 1'b1, 3'b000, 3'b000, 8'd0});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{24'hFF3C3C, 3'b111, 1'b0, 8'h3C, 1'b1, 3'b100, 3'b000, 8'd0});
    vecs.push_back('{24'hFF3C3C, 3'b111, 1'b0, 8'h3C, 1'b1, 3'b100, 3'b100, 8'd0});
    vecs.push_back('{24'hFF2211, 3'b111, 1'b0, 8'h00, 1'b0, 3'b000, 3'b100, 8'd1});
    vecs.push_back('{24'hFF3C3C, 3'b111, 1'b1, 8'h3C, 1'b1, 3'b000, 3'b000, 8'd1});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{24'hFF3C3C, 3'b111, 1'b0, 8'h3C, 1'b1, 3'b100, 3'b000, 8'd1});
    vecs.push_back('{24'h3C3C3C, 3'b111, 1'b0, 8'h3C, 1'b1, 3'b000, 3'b000, 8'd1});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{24'hFF3C3C, 3'b111, 1'b0, 8'h3C, 1'b1, 3'b100, 3'b000, 8'd1});
    vecs.push_back('{24'hFF3C3C, 3'b111, 1'b0, 8'h3C, 1'b1, 3'b100, 3'b100, 8'd1});
    vecs.push_back('{24'h3C3C3C, 3'b011, 1'b0, 8'h3C, 1'b1, 3'b000, 3'b100, 8'd1});
    vecs.push_back('{24'h3C3C3C, 3'b001, 1'b0, 8'h00, 1'b0, 3'b000, 3'b100, 8'd2});
    vecs.push_back('{24'h332211, 3'b111, 1'b1, 8'h00, 1'b0, 3'b000, 3'b000, 8'd3});
    vecs.push_back('{24'h332211, 3'b111, 1'b0, 8'h00, 1'b0, 3'b000, 3'b000, 8'd4});
    vecs.push_back('{24'h5A5A00, 3'b111, 1'b0, 8'h5A, 1'b1, 3'b001, 3'b000, 8'd4});

    // Reset held two cycles with a beat offered.
    cycle(1, 1, 24'hA5A5A5, 3'b111, 0, 1);
    cycle(1, 1, 24'hA5A5A5, 3'b111, 0, 1);
    rst = 0; bus.in_valid = 0; bus.out_ready = 0;
    #1;
    chk("rst in_ready",     32'(bus.in_ready),     32'(1));
    chk("rst out_valid",    32'(bus.out_valid),    32'(0));
    chk("rst out_data",     32'(bus.out_data),     32'(0));
    chk("rst out_majority", 32'(bus.out_majority), 32'(0));
    chk("rst out_disagree", 32'(bus.out_disagree), 32'(0));
    chk("rst fault",        32'(fault),            32'(0));
    chk("rst nomaj_count",  32'(nomaj),            32'(0));

    for (int k = 0; k < vecs.size(); k++) begin
      cycle(0, 1, vecs[k].data, vecs[k].en, vecs[k].clr, 1);
      chk($sformatf("vec%0d out_valid", k),    32'(bus.out_valid),    32'(1));
      chk($sformatf("vec%0d out_data", k),     32'(bus.out_data),     32'(vecs[k].e_data));
      chk($sformatf("vec%0d out_majority", k), 32'(bus.out_majority), 32'(vecs[k].e_maj));
      chk($sformatf("vec%0d out_disagree", k), 32'(bus.out_disagree), 32'(vecs[k].e_dis));
      chk($sformatf("vec%0d fault", k),        32'(fault),            32'(vecs[k].e_fault));
      chk($sformatf("vec%0d nomaj_count", k),  32'(nomaj),            32'(vecs[k].e_nomaj));
    end

    // Backpressure: second beat waits until out_ready returns.
    cycle(0, 0, '0, 3'b111, 0, 1);
    chk("bp drain out_valid", 32'(bus.out_valid), 32'(0));
    cycle(0, 1, 24'h777777, 3'b111, 0, 0);
    chk("bp first out_data", 32'(bus.out_data), 32'(8'h77));
    chk("bp stalled in_ready", 32'(bus.in_ready), 32'(0));
    cycle(0, 1, 24'h559999, 3'b111, 0, 0);
    chk("bp hold out_valid", 32'(bus.out_valid), 32'(1));
    chk("bp hold out_data",  32'(bus.out_data),  32'(8'h77));
    chk("bp hold disagree",  32'(bus.out_disagree), 32'(0));
    cycle(0, 1, 24'h559999, 3'b111, 0, 1);
    chk("bp second out_data", 32'(bus.out_data),     32'(8'h99));
    chk("bp second disagree", 32'(bus.out_disagree), 32'(3'b100));
    check_model("bp");

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      base = W'($urandom_range(0, 3));
      for (int i = 0; i < N; i++)
        d[i*W +: W] = ($urandom_range(0, (i == N-1) ? 1 : 4) == 0) ? W'($urandom_range(0, 3)) : base;
      e    = ($urandom_range(0, 7) == 0) ? N'($urandom) : {N{1'b1}};
      c    = ($urandom_range(0, 40) == 0);
      r    = ($urandom_range(0, 150) == 0);
      vld  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(r, vld, d, e, c, ordy);
      check_model("rand");
    end

    // Saturation of the no-majority counter, then reset clears it.
    cycle(0, 0, '0, 3'b111, 1, 1);
    for (int k = 0; k < 270; k++) cycle(0, 1, 24'h010203, 3'b001, 0, 1);
    chk("sat nomaj_count", 32'(nomaj), 32'(8'hFF));
    check_model("sat");
    cycle(1, 0, '0, 3'b111, 0, 1);
    chk("sat reset nomaj_count", 32'(nomaj), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
